// File: rtl/conv_output.sv
// conv_output: buffers one group-major conv tile and re-emits it pixel-major.
// Define CONV_OUTPUT_PINGPONG_EN for two banks so the next tile fills while the previous drains.
module conv_output #(
  parameter int DATA_W    = 64,
  parameter int CFG_W     = 16,
  parameter int BUF_DEPTH = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CFG_W-1:0]  In_Channel,
  input  logic [CFG_W-1:0]  Matrix_Col,
  input  logic [CFG_W-1:0]  Matrix_Row,
  input  logic [DATA_W-1:0] sData,
  input  logic              sValid,
  output logic              sReady,
  output logic [DATA_W-1:0] mData_payload,
  output logic              mData_valid,
  input  logic              mData_ready
);
  localparam int AW = $clog2(BUF_DEPTH);
  localparam int CW = AW + 1;
`ifdef CONV_OUTPUT_PINGPONG_EN
  localparam int NB = 2;
  localparam int MW = AW + 1;
  localparam logic PP = 1'b1;
`else
  localparam int NB = 1;
  localparam int MW = AW;
  localparam logic PP = 1'b0;
`endif
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_next;
  logic [CW-1:0] g_in, p_in, n_in;
  logic [AW-1:0] g_r;
  logic [CW-1:0] p_r, n_r;
  logic [CW-1:0] wcnt, wp, rcnt, ocnt;
  logic [AW-1:0] wg, waddr;
  logic [1:0] full;
  logic wb, rb;
  logic wr, re, adv, xfer, done, s1_v;
  logic [MW-1:0] widx, ridx;
  logic [DATA_W-1:0] mem [NB*BUF_DEPTH];
  logic [DATA_W-1:0] q;
`ifdef CONV_OUTPUT_PINGPONG_EN
  assign widx = {wb, waddr};
  assign ridx = {rb, rcnt[AW-1:0]};
`else
  assign widx = waddr;
  assign ridx = rcnt[AW-1:0];
`endif
  assign sReady = (state == RUN) && !full[wb];
  always_comb begin
    state_next = start ? RUN : state;
    g_in = CW'(In_Channel >> 3);
    p_in = CW'(Matrix_Row) * CW'(Matrix_Col);
    n_in = g_in * p_in;
    wr = sValid && sReady && !start;
    adv = !mData_valid || mData_ready;
    xfer = mData_valid && mData_ready;
    re = (state == RUN) && full[rb] && (rcnt != n_r) && (!s1_v || adv);
    done = xfer && (ocnt == n_r - CW'(1));
  end
  // Synchronous RAM; q only moves on a read so it holds while the output stalls.
  always_ff @(posedge clk) begin
    if (wr) mem[widx] <= sData;
    if (re) q <= mem[ridx];
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      g_r <= '0;
      p_r <= '0;
      n_r <= '0;
      full <= '0;
      wb <= 1'b0;
      rb <= 1'b0;
      wcnt <= '0;
      wp <= '0;
      wg <= '0;
      waddr <= '0;
      rcnt <= '0;
      ocnt <= '0;
      s1_v <= 1'b0;
      mData_valid <= 1'b0;
      mData_payload <= '0;
    end else begin
      state <= state_next;
      if (start) begin
        g_r <= g_in[AW-1:0];
        p_r <= p_in;
        n_r <= n_in;
        full <= '0;
        wb <= 1'b0;
        rb <= 1'b0;
        wcnt <= '0;
        wp <= '0;
        wg <= '0;
        waddr <= '0;
        rcnt <= '0;
        ocnt <= '0;
        s1_v <= 1'b0;
        mData_valid <= 1'b0;
      end else begin
        // Word k lands at p*G+g: stride G per pixel, restart at the next group on pixel wrap.
        if (wr) begin
          if (wcnt == n_r - CW'(1)) begin
            wcnt <= '0;
            wp <= '0;
            wg <= '0;
            waddr <= '0;
            full[wb] <= 1'b1;
            wb <= wb ^ PP;
          end else if (wp == p_r - CW'(1)) begin
            wcnt <= wcnt + CW'(1);
            wp <= '0;
            wg <= wg + AW'(1);
            waddr <= wg + AW'(1);
          end else begin
            wcnt <= wcnt + CW'(1);
            wp <= wp + CW'(1);
            waddr <= waddr + g_r;
          end
        end
        s1_v <= re || (s1_v && !adv);
        if (adv) mData_valid <= s1_v;
        if (adv && s1_v) mData_payload <= q;
        if (done) begin
          full[rb] <= 1'b0;
          rb <= rb ^ PP;
          rcnt <= '0;
          ocnt <= '0;
        end else begin
          if (re) rcnt <= rcnt + CW'(1);
          if (xfer) ocnt <= ocnt + CW'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_conv_output.sv
// tb_conv_output: randomized bench with a queue-based tile reorder model.
module tb_conv_output;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic [15:0] In_Channel = '0;
  logic [15:0] Matrix_Col = '0;
  logic [15:0] Matrix_Row = '0;
  logic [63:0] sData = '0;
  logic sValid = 1'b0;
  logic sReady;
  logic [63:0] mData_payload;
  logic mData_valid;
  logic mData_ready = 1'b0;

  conv_output dut (
    .clk(clk), .reset(reset), .start(start),
    .In_Channel(In_Channel), .Matrix_Col(Matrix_Col), .Matrix_Row(Matrix_Row),
    .sData(sData), .sValid(sValid), .sReady(sReady),
    .mData_payload(mData_payload), .mData_valid(mData_valid), .mData_ready(mData_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  int cyc = 0;
  logic [63:0] in_q[$];
  logic [63:0] tile[$];
  logic [63:0] exp_q[$];
  int g_m = 1;
  int p_m = 1;
  int rdy_mode = 0;
  bit v_gate = 1'b0;
  int out_cnt = 0;
  bit lat_arm = 1'b0;
  bit lat_wait = 1'b0;
  int last_hs = 0;
  bit ovl = 1'b0;
  bit prev_stall = 1'b0;
  bit prev_start = 1'b0;
  logic [63:0] prev_pay = '0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk);
    #1;
    mData_ready = (rdy_mode == 0) || (rdy_mode == 1 && cyc % 3 == 0) ||
                  (rdy_mode == 2 && $urandom_range(0, 1) == 1);
    sValid = (in_q.size() != 0) && (!v_gate || cyc % 513 < 64);
    sData = (in_q.size() != 0) ? in_q[0] : 64'd0;
  end

  // Model: a completed tile of G*P words is emitted as out[j] = in[(j%G)*P + j/G].
  initial forever begin
    @(negedge clk);
    if (!reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && !prev_start) begin
        check("hold_valid", 64'(mData_valid), 64'd1);
        check("hold_data", mData_payload, prev_pay);
      end
      if (lat_wait && mData_valid) begin
        check("latency", 64'(cyc - last_hs), 64'd2);
        lat_wait = 1'b0;
      end
      if (mData_valid && mData_ready) begin
        check("exp_avail", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) check("payload", mData_payload, exp_q.pop_front());
        out_cnt++;
      end
      if (start) begin
        tile.delete();
        exp_q.delete();
        g_m = int'(In_Channel) / 8;
        p_m = int'(Matrix_Row) * int'(Matrix_Col);
      end else if (sValid && sReady) begin
        if (mData_valid) ovl = 1'b1;
        tile.push_back(sData);
        void'(in_q.pop_front());
        if (tile.size() == g_m * p_m) begin
          for (int j = 0; j < g_m * p_m; j++) exp_q.push_back(tile[(j % g_m) * p_m + j / g_m]);
          tile.delete();
          if (lat_arm) begin
            last_hs = cyc + 1;
            lat_wait = 1'b1;
            lat_arm = 1'b0;
          end
        end
      end
      prev_stall = mData_valid && !mData_ready;
      prev_pay = mData_payload;
      prev_start = start;
    end
  end

  task automatic do_start(input int ic, input int col, input int row);
    @(posedge clk);
    #1;
    In_Channel = 16'(ic);
    Matrix_Col = 16'(col);
    Matrix_Row = 16'(row);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while ((in_q.size() != 0 || exp_q.size() != 0 || mData_valid) && n < budget) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    check({tag, "_in"}, 64'(in_q.size()), 64'd0);
    check({tag, "_out"}, 64'(exp_q.size()), 64'd0);
    check({tag, "_part"}, 64'(tile.size()), 64'd0);
  endtask

  initial begin
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("rst_sready", 64'(sReady), 64'd0);
    check("rst_valid", 64'(mData_valid), 64'd0);
    check("rst_payload", mData_payload, 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle_sready", 64'(sReady), 64'd0);
    end
    rdy_mode = 0;
    do_start(32, 14, 2);
    lat_arm = 1'b1;
    out_cnt = 0;
    for (int k = 0; k < 112; k++) in_q.push_back(64'(k));
    drain("reorder", 2000);
    check("reorder_cnt", 64'(out_cnt), 64'd112);
    check("latency_seen", 64'(lat_wait), 64'd0);
    rdy_mode = 1;
    out_cnt = 0;
    ovl = 1'b0;
    for (int k = 0; k < 224; k++) in_q.push_back(64'(k % 112));
    drain("backpr", 5000);
    check("backpr_cnt", 64'(out_cnt), 64'd224);
`ifdef CONV_OUTPUT_PINGPONG_EN
    check("overlap", 64'(ovl), 64'd1);
`else
    check("overlap", 64'(ovl), 64'd0);
`endif
    rdy_mode = 2;
    v_gate = 1'b1;
    out_cnt = 0;
    for (int k = 0; k < 896; k++) in_q.push_back({$urandom, $urandom});
    drain("stream", 20000);
    check("stream_cnt", 64'(out_cnt), 64'd896);
    v_gate = 1'b0;
    rdy_mode = 0;
    out_cnt = 0;
    do_start(32, 14, 2);
    for (int k = 0; k < 50; k++) in_q.push_back({$urandom, $urandom});
    for (int n = 0; n < 500 && in_q.size() != 0; n++) @(negedge clk);
    check("restart_fed", 64'(in_q.size()), 64'd0);
    do_start(8, 3, 1);
    for (int k = 0; k < 3; k++) in_q.push_back({$urandom, $urandom});
    drain("restart", 500);
    check("restart_cnt", 64'(out_cnt), 64'd3);
    rdy_mode = 2;
    out_cnt = 0;
    do_start(8, 1, 1);
    for (int k = 0; k < 6; k++) in_q.push_back({$urandom, $urandom});
    drain("degen", 500);
    check("degen_cnt", 64'(out_cnt), 64'd6);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
